// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the SDRAM port arbiter.
// Imported by mem_arbiter, rr_pick2 and mem_arbiter_if.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int MEM_AW = 24;
   localparam int MEM_DW = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and SDRAM-controller signals of the arbiter.
// slave = arbiter view, master = environment (requesters + controller).
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
) ();

   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdata;
   logic          err;
   logic [AW-1:0] sd_addr;
   logic [DW-1:0] sd_wdata;
   logic          sd_read;
   logic          sd_write;
   logic          sd_busy;
   logic          sd_ready;
   logic [DW-1:0] sd_rdata;

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      input  sd_busy, sd_ready, sd_rdata,
      output ack0, ack1, rdata, err,
      output sd_addr, sd_wdata,
      output sd_read, sd_write
   );

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      output sd_busy, sd_ready, sd_rdata,
      input  ack0, ack1, rdata, err,
      input  sd_addr, sd_wdata,
      input  sd_read, sd_write
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
// On contention the port not granted last wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   // Alternate on contention, otherwise take the lone requester.
   always_comb begin
      grant = PORT_CPU;
      unique case (1'b1)
         (req == 2'b11):     grant = ~last;
         (req[1] & ~req[0]): grant = PORT_DMA;
         default:            grant = PORT_CPU;
      endcase
   end

   assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SDRAM controller port between CPU and DMA.
// Optional watchdog abort when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = MEM_AW,
   parameter int DW      = MEM_DW,
   parameter int TIMEOUT = 255
) (
   input logic          clki,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          own_q, own_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          grant;
   logic          valid;
   logic          abort;
   logic          pick_we;

   rr_pick2 u_pick (
      .req   ({bus.req1, bus.req0}),
      .last  (last_q),
      .grant (grant),
      .valid (valid)
   );

   assign pick_we = grant ? bus.we1 : bus.we0;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q;
   logic          err_q;

   // Watchdog: zero while idle, so it restarts on every ISSUE entry.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (state_q == IDLE)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + TW'(1);
   end

   assign abort = (state_q != IDLE) && !bus.sd_ready &&
                  (cnt_q == TW'(TIMEOUT - 1));

   // Error flag rides along with the aborting ack.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else
         err_q <= abort;
   end

   assign bus.err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = TIMEOUT[0];
   assign abort          = 1'b0;
   assign bus.err        = 1'b0;
`endif

   // Next state, latched request and registered outputs.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      own_d   = own_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      rd_d    = rd_q;
      wr_d    = wr_q;
      unique case (state_q)
         IDLE: begin
            // Skip the ack cycle: the requester still holds req there.
            if (valid && !bus.sd_busy && !ack0_q && !ack1_q) begin
               own_d   = grant;
               we_d    = pick_we;
               addr_d  = grant ? bus.addr1 : bus.addr0;
               wdata_d = grant ? bus.wdata1 : bus.wdata0;
               rd_d    = ~pick_we;
               wr_d    = pick_we;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (bus.sd_ready) begin
               if (!we_q)
                  rdata_d = bus.sd_rdata;
               ack0_d  = (own_q == PORT_CPU);
               ack1_d  = (own_q == PORT_DMA);
               last_d  = own_q;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = IDLE;
            end else if (abort) begin
               ack0_d  = (own_q == PORT_CPU);
               ack1_d  = (own_q == PORT_DMA);
               last_d  = own_q;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = IDLE;
            end else if (state_q == ISSUE && bus.sd_busy) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = WAIT;
            end
         end
         default: begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; port 0 wins the first contention.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= PORT_DMA;
         own_q   <= PORT_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         own_q   <= own_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.rdata    = rdata_q;
   assign bus.sd_addr  = addr_q;
   assign bus.sd_wdata = wdata_q;
   assign bus.sd_read  = rd_q;
   assign bus.sd_write = wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small SDRAM model.
// Timeout steps run when MEM_ARB_TIMEOUT_EN is defined (TIMEOUT = 20).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO = 20;
`else
   localparam int TO = 255;
`endif

   logic clki = 1'b0;
   logic rst_n = 1'b0;

   always #5 clki = ~clki;

   mem_arbiter_if #(.AW(24), .DW(16)) bus ();

   mem_arbiter #(
      .AW      (24),
      .DW      (16),
      .TIMEOUT (TO)
   ) dut (
      .clki  (clki),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic        m_busy;
   logic        force_busy = 1'b0;
   logic        never_ready = 1'b0;
   logic [15:0] rd_val = '0;
   int          m_cnt;

   assign bus.sd_busy = m_busy | force_busy;

   // Controller model: busy one cycle after a strobe, ready 5 later.
   always @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         m_busy       <= 1'b0;
         m_cnt        <= 0;
         bus.sd_ready <= 1'b0;
         bus.sd_rdata <= '0;
      end else begin
         #1;
         bus.sd_ready <= 1'b0;
         if (!m_busy) begin
            if (bus.sd_read || bus.sd_write) begin
               m_busy <= 1'b1;
               m_cnt  <= 0;
            end
         end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt >= 4 && !never_ready) begin
               bus.sd_ready <= 1'b1;
               bus.sd_rdata <= rd_val;
               m_busy       <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for an ack; who = 0/1, 2 if both, -1 if none in budget.
   task automatic wait_ack(input int maxc, output int who,
                           output int c_rdy, output int c_ack,
                           output logic [15:0] rd, output logic e);
      who   = -1;
      c_rdy = -1;
      c_ack = -1;
      rd    = '0;
      e     = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clki);
         if (bus.sd_ready && c_rdy < 0)
            c_rdy = i;
         if (bus.ack0 || bus.ack1) begin
            c_ack = i;
            who   = (bus.ack0 && bus.ack1) ? 2 : (bus.ack1 ? 1 : 0);
            rd    = bus.rdata;
            e     = bus.err;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          who;
      int          c_rdy;
      int          c_ack;
      logic [15:0] rd;
      logic        e;
      logic        seen;

      bus.req0   = 1'b0;
      bus.req1   = 1'b0;
      bus.we0    = 1'b0;
      bus.we1    = 1'b0;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;

      // Reset: quiet for 10 cycles after release.
      repeat (3) @(negedge clki);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (10) begin
         @(negedge clki);
         if (bus.sd_read || bus.sd_write || bus.ack0 ||
             bus.ack1 || bus.err)
            seen = 1'b1;
      end
      chk("rst_activity", 32'(seen), 0);
      chk("rst_sd_read", 32'(bus.sd_read), 0);
      chk("rst_sd_write", 32'(bus.sd_write), 0);
      chk("rst_sd_addr", 32'(bus.sd_addr), 0);
      chk("rst_sd_wdata", 32'(bus.sd_wdata), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_err", 32'(bus.err), 0);

      // Single read from port 0.
      bus.req0  = 1'b1;
      bus.we0   = 1'b0;
      bus.addr0 = 24'h000123;
      rd_val    = 16'hBEEF;
      @(negedge clki);
      chk("rd_strobe", 32'(bus.sd_read), 1);
      chk("rd_no_write", 32'(bus.sd_write), 0);
      chk("rd_addr", 32'(bus.sd_addr), 32'h000123);
      wait_ack(30, who, c_rdy, c_ack, rd, e);
      bus.req0 = 1'b0;
      chk("rd_who", 32'(who), 0);
      chk("rd_ready_to_ack", 32'(c_ack - c_rdy), 1);
      chk("rd_rdata", 32'(rd), 32'hBEEF);
      chk("rd_err", 32'(e), 0);
      @(negedge clki);
      chk("rd_ack_pulse", 32'(bus.ack0), 0);

      // Contention after reset: grants alternate starting with port 0.
      rst_n = 1'b0;
      @(negedge clki);
      rst_n     = 1'b1;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.we0   = 1'b0;
      bus.we1   = 1'b0;
      bus.addr0 = 24'h000010;
      bus.addr1 = 24'h000020;
      for (int k = 0; k < 4; k++) begin
         rd_val = 16'hA000 + 16'(k);
         wait_ack(40, who, c_rdy, c_ack, rd, e);
         chk($sformatf("rr_grant%0d", k), 32'(who), 32'(k % 2));
         chk($sformatf("rr_rdata%0d", k), 32'(rd), 32'hA000 + 32'(k));
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;

      // Write from port 1 at the top address.
      @(negedge clki);
      bus.req1   = 1'b1;
      bus.we1    = 1'b1;
      bus.addr1  = 24'hFFFFFF;
      bus.wdata1 = 16'h5A5A;
      rd_val     = 16'h1111;
      @(negedge clki);
      chk("wr_strobe", 32'(bus.sd_write), 1);
      chk("wr_no_read", 32'(bus.sd_read), 0);
      chk("wr_addr", 32'(bus.sd_addr), 32'hFFFFFF);
      chk("wr_wdata", 32'(bus.sd_wdata), 32'h5A5A);
      wait_ack(30, who, c_rdy, c_ack, rd, e);
      bus.req1 = 1'b0;
      bus.we1  = 1'b0;
      chk("wr_who", 32'(who), 1);
      chk("wr_rdata_kept", 32'(rd), 32'hA003);

      // Busy gating: no strobe while the controller is busy.
      @(negedge clki);
      force_busy = 1'b1;
      bus.req0   = 1'b1;
      bus.addr0  = 24'h000055;
      rd_val     = 16'h2222;
      seen       = 1'b0;
      repeat (5) begin
         @(negedge clki);
         if (bus.sd_read || bus.sd_write)
            seen = 1'b1;
      end
      chk("busy_no_strobe", 32'(seen), 0);
      force_busy = 1'b0;
      @(negedge clki);
      chk("busy_strobe_after", 32'(bus.sd_read), 1);
      wait_ack(30, who, c_rdy, c_ack, rd, e);
      bus.req0 = 1'b0;
      chk("busy_who", 32'(who), 0);
      chk("busy_rdata", 32'(rd), 32'h2222);

`ifdef MEM_ARB_TIMEOUT_EN
      // Timeout: controller never completes.
      @(negedge clki);
      never_ready = 1'b1;
      bus.req0    = 1'b1;
      bus.addr0   = 24'h000077;
      @(negedge clki);
      chk("to_strobe", 32'(bus.sd_read), 1);
      wait_ack(40, who, c_rdy, c_ack, rd, e);
      bus.req0    = 1'b0;
      never_ready = 1'b0;
      chk("to_who", 32'(who), 0);
      chk("to_within", 32'(c_ack >= 0 && c_ack + 1 <= 21), 1);
      chk("to_err", 32'(e), 1);
      chk("to_rdata_kept", 32'(rd), 32'h2222);
      repeat (3) @(negedge clki);
      bus.req0  = 1'b1;
      bus.addr0 = 24'h000078;
      rd_val    = 16'h3333;
      wait_ack(30, who, c_rdy, c_ack, rd, e);
      bus.req0 = 1'b0;
      chk("to_next_who", 32'(who), 0);
      chk("to_next_err", 32'(e), 0);
      chk("to_next_rdata", 32'(rd), 32'h3333);
`endif

      // Reset while waiting on the controller.
      @(negedge clki);
      never_ready = 1'b1;
      bus.req0    = 1'b1;
      bus.addr0   = 24'h000099;
      @(negedge clki);
      chk("rw_strobe", 32'(bus.sd_read), 1);
      repeat (3) @(negedge clki);
      rst_n = 1'b0;
      #1;
      chk("rw_sd_read", 32'(bus.sd_read), 0);
      chk("rw_sd_write", 32'(bus.sd_write), 0);
      chk("rw_state", 32'(dut.state_q), 32'(IDLE));
      bus.req0    = 1'b0;
      never_ready = 1'b0;
      @(negedge clki);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (6) begin
         @(negedge clki);
         if (bus.ack0 || bus.ack1 || bus.sd_read || bus.sd_write)
            seen = 1'b1;
      end
      chk("rw_no_ack", 32'(seen), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
